ifid_stage_reg: RTL and testbench



---
 rtl/ifid_pkg.sv | 12 +
 rtl/ifid_kill_ctr.sv | 38 +++
 rtl/ifid_stage_reg.sv | 111 +++++++++++
 tb/tb_ifid_stage_reg.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/ifid_pkg.sv
// Shared constants and helpers for the IF/ID pipeline register.
package ifid_pkg;

  // Default squash word; all-zero unless a core overrides NOP_INST.
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  // Width needed to hold the kill-window depth 0..kill_cycles.
  function automatic int kill_w(input int kill_cycles);
    return $clog2(kill_cycles + 1);
  endfunction

endpackage

// File: rtl/ifid_kill_ctr.sv
// Loadable down-counter that tracks the post-flush squash window.
module ifid_kill_ctr
  import ifid_pkg::*;
#(
  parameter int W = 1,
  parameter logic [W-1:0] LOAD_VAL = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  output logic [W-1:0] count,
  output logic         active
);

  logic [W-1:0] count_q;

  // Window counter: a load restarts the window even if it is still open.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {W{1'b0}};
    end else if (en) begin
      if (load) begin
        count_q <= LOAD_VAL;
      end else if (count_q != {W{1'b0}}) begin
        count_q <= count_q - W'(1);
      end else begin
        count_q <= count_q;
      end
    end else begin
      count_q <= count_q;
    end
  end

  assign count  = count_q;
  assign active = (count_q != {W{1'b0}});

endmodule

// File: rtl/ifid_stage_reg.sv
// IF/ID pipeline register: PC latch, flush kill window, hazard-hold replay
// buffer, valid flag and bubble counter.
module ifid_stage_reg
  import ifid_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter int KILL_CYCLES = 1,
  parameter logic [ILEN-1:0] NOP_INST = ILEN'(NOP_DEFAULT),
  parameter logic [XLEN-1:0] FLUSH_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            init,
  input  logic            flush,
  input  logic            hold,
  input  logic            ext_stall,
  input  logic [XLEN-1:0] pc_in,
  input  logic [ILEN-1:0] inst_in,
  output logic [XLEN-1:0] pc_out,
  output logic [ILEN-1:0] inst_out,
  output logic            valid_out,
  output logic [31:0]     bubble_cnt
);

  localparam int KILL_W = kill_w(KILL_CYCLES);

  logic [XLEN-1:0]   pc_q;
  logic              hold_q;
  logic [ILEN-1:0]   skid_q;
  logic [KILL_W-1:0] kill_q;
  logic [31:0]       bubble_q;

  logic              advance_s;
  logic              kill_active_s;
  logic [ILEN-1:0]   inst_s;
  logic              valid_s;

  assign advance_s = ~ext_stall;

  ifid_kill_ctr #(
    .W        (KILL_W),
    .LOAD_VAL (KILL_W'(KILL_CYCLES))
  ) u_kill_ctr (
    .clk    (clk),
    .rst    (rst),
    .en     (advance_s),
    .load   (flush),
    .count  (kill_q),
    .active (kill_active_s)
  );

  // Output word selection; a replayed word's validity still follows the kill window.
  always_comb begin
    inst_s  = inst_in;
    valid_s = 1'b1;
    if (init) begin
      inst_s  = NOP_INST;
      valid_s = 1'b0;
    end else if (hold_q) begin
      inst_s  = skid_q;
      valid_s = ~kill_active_s;
    end else if (kill_active_s) begin
      inst_s  = NOP_INST;
      valid_s = 1'b0;
    end else begin
      inst_s  = inst_in;
      valid_s = 1'b1;
    end
  end

  // PC, hold flag and replay buffer; the buffer captures the selected word.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= {XLEN{1'b0}};
      hold_q <= 1'b0;
      skid_q <= {ILEN{1'b0}};
    end else if (advance_s) begin
      if (flush) begin
        pc_q <= FLUSH_PC;
      end else if (hold) begin
        pc_q <= pc_q;
      end else begin
        pc_q <= pc_in;
      end
      hold_q <= hold & ~flush;
      skid_q <= inst_s;
    end else begin
      pc_q   <= pc_q;
      hold_q <= hold_q;
      skid_q <= skid_q;
    end
  end

  // Bubble counter: advancing cycles that deliver no valid instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_q <= 32'd0;
    end else if (advance_s && !valid_s) begin
      bubble_q <= bubble_q + 32'd1;
    end else begin
      bubble_q <= bubble_q;
    end
  end

  assign pc_out     = pc_q;
  assign inst_out   = inst_s;
  assign valid_out  = valid_s;
  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_ifid_stage_reg.sv
// Scoreboard bench for ifid_stage_reg: hand-derived expectations are queued
// as each cycle's stimulus is driven and compared on the following negedge.
module tb_ifid_stage_reg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam int KILL_CYCLES = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] FPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, init, flush, hold, ext_stall;
  logic [31:0] pc_in, inst_in;
  logic [31:0] pc_out, inst_out, bubble_cnt;
  logic        valid_out;

  always #5 clk = ~clk;

  ifid_stage_reg #(
    .XLEN        (XLEN),
    .ILEN        (ILEN),
    .KILL_CYCLES (KILL_CYCLES),
    .NOP_INST    (NOP),
    .FLUSH_PC    (FPC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .init       (init),
    .flush      (flush),
    .hold       (hold),
    .ext_stall  (ext_stall),
    .pc_in      (pc_in),
    .inst_in    (inst_in),
    .pc_out     (pc_out),
    .inst_out   (inst_out),
    .valid_out  (valid_out),
    .bubble_cnt (bubble_cnt)
  );

  typedef struct packed {
    logic [7:0]  row;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic [31:0] bub;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_fails  = 0;
  int   row_n    = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      cur = sb_q.pop_front();
      check_eq($sformatf("r%0d pc", cur.row), pc_out, cur.pc);
      check_eq($sformatf("r%0d inst", cur.row), inst_out, cur.inst);
      check_eq($sformatf("r%0d valid", cur.row), {31'd0, valid_out}, {31'd0, cur.valid});
      check_eq($sformatf("r%0d bubble", cur.row), bubble_cnt, cur.bub);
    end
  end

  task automatic row(input logic r, input logic fl, input logic ho, input logic es,
                     input logic in_i, input logic [31:0] pci, input logic [31:0] insti,
                     input logic [31:0] epc, input logic [31:0] einst,
                     input logic ev, input logic [31:0] ebub);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    flush     = fl;
    hold      = ho;
    ext_stall = es;
    init      = in_i;
    pc_in     = pci;
    inst_in   = insti;
    e.row   = 8'(row_n);
    e.pc    = epc;
    e.inst  = einst;
    e.valid = ev;
    e.bub   = ebub;
    sb_q.push_back(e);
    row_n++;
  endtask

  initial begin
    rst = 1'b1; init = 1'b0; flush = 1'b0; hold = 1'b0; ext_stall = 1'b0;
    pc_in = 32'h0; inst_in = 32'h0;
    repeat (2) @(posedge clk);

    //  rst fl ho es in  pc_in         inst_in       exp_pc        exp_inst      v     bub
    row(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'hAAAA_0000, 32'h0000_0000, 32'hAAAA_0000, 1'b1, 32'd0);
    // streaming
    row(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'hA000_0001, 32'h0000_0000, 32'hA000_0001, 1'b1, 32'd0);
    row(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0004, 32'hB000_0002, 32'h0000_0000, 32'hB000_0002, 1'b1, 32'd0);
    row(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0008, 32'hC000_0003, 32'h0000_0004, 32'hC000_0003, 1'b1, 32'd0);
    // flush, two squashed cycles
    row(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_000C, 32'hD000_0004, 32'h0000_0008, 32'hD000_0004, 1'b1, 32'd0);
    row(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'hE000_0005, FPC,           NOP,           1'b0, 32'd0);
    row(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0014, 32'hF000_0006, 32'h0000_0010, NOP,           1'b0, 32'd1);
    row(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0104, 32'h1000_0007, 32'h0000_0014, 32'h1000_0007, 1'b1, 32'd2);
    // three-cycle hold replays W
    row(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0108, 32'h5555_0008, 32'h0000_0104, 32'h5555_0008, 1'b1, 32'd2);
    row(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_010C, 32'h7777_0009, 32'h0000_0104, 32'h5555_0008, 1'b1, 32'd2);
    row(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0110, 32'h8888_000A, 32'h0000_0104, 32'h5555_0008, 1'b1, 32'd2);
    row(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0108, 32'h9999_000B, 32'h0000_0104, 32'h5555_0008, 1'b1, 32'd2);
    row(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_010C, 32'h2000_000C, 32'h0000_0108, 32'h2000_000C, 1'b1, 32'd2);
    // flush, then ext_stall for 4 cycles with one kill cycle left
    row(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'h3000_000D, 32'h0000_010C, 32'h3000_000D, 1'b1, 32'd2);
    row(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0204, 32'h4000_000E, FPC,           NOP,           1'b0, 32'd2);
    for (int i = 0; i < 4; i++) begin
      row(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0208, 32'h6000_000F, 32'h0000_0204, NOP,         1'b0, 32'd3);
    end
    row(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0208, 32'h6100_0010, 32'h0000_0204, NOP,           1'b0, 32'd3);
    row(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_020C, 32'h6200_0011, 32'h0000_0208, 32'h6200_0011, 1'b1, 32'd4);
    // flush together with hold: no replay, kill window runs
    row(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0210, 32'h6300_0012, 32'h0000_020C, 32'h6300_0012, 1'b1, 32'd4);
    row(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0300, 32'h6400_0013, FPC,           NOP,           1'b0, 32'd4);
    row(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0304, 32'h6500_0014, 32'h0000_0300, NOP,           1'b0, 32'd5);
    // init squashes immediately but still counts a bubble
    row(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0308, 32'h6600_0015, 32'h0000_0304, NOP,           1'b0, 32'd6);
    row(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_030C, 32'h6700_0016, 32'h0000_0308, 32'h6700_0016, 1'b1, 32'd7);
    // reset in the middle of a hold
    row(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0310, 32'h6800_0017, 32'h0000_030C, 32'h6800_0017, 1'b1, 32'd7);
    row(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0314, 32'h6900_0018, 32'h0000_030C, 32'h6800_0017, 1'b1, 32'd7);
    row(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0318, 32'h6A00_0019, 32'h0000_0000, 32'h6A00_0019, 1'b1, 32'd0);
    row(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_031C, 32'h6B00_001A, 32'h0000_0318, 32'h6B00_001A, 1'b1, 32'd0);

    @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
